// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the BCD conversion arbiter.
// Contents:
//   state_t    : top-level FSM states (IDLE, SHIFT, DONE)
//   ADJ_THRESH : digit value at or above which double-dabble adds 3
//   ADJ_ADD    : correction added to such a digit before each shift
//   ndig_min() : decimal digits needed to print 2^width-1, used to
//                reject parameter sets whose NDIG is too small
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Counts decimal digits of the largest unsigned value of the given width.
    function automatic int ndig_min(input int width);
        longint unsigned maxv;
        int n;
        maxv = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (maxv != 64'd0) begin
                maxv = maxv / 64'd10;
                n = n + 1;
            end
        end
        if (n == 0) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_conversion_arbiter_if.sv
// Request/result bundle of the BCD conversion arbiter.
//   req        : per-requester request level
//   value      : packed binary values, requester i at [i*WIDTH +: WIDTH]
//   ack        : one-hot one-cycle pulse, value of that requester latched
//   busy       : arbiter is converting or holding a result
//   out_valid  : result available
//   out_ready  : consumer accepts result
//   out_id     : index of the requester the result belongs to
//   out_digits : BCD result, digit k (10^k) at [k*4 +: 4]
// master = requesters + consumer side, slave = arbiter side.
interface bcd_conversion_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int NDIG  = 3
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] value;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDW-1:0]        out_id;
    logic [NDIG*4-1:0]     out_digits;

    modport master (
        output req, value, out_ready,
        input  ack, busy, out_valid, out_id, out_digits
    );

    modport slave (
        input  req, value, out_ready,
        output ack, busy, out_valid, out_id, out_digits
    );

endinterface

// File: rtl/bcd_dabble_core.sv
// Sequential shift-and-add-3 binary-to-BCD engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin, clear accumulator, counter = WIDTH
//   shift_en   : perform one adjust-and-shift step this cycle
//   bin        : binary value to convert (sampled on start)
//   digits     : BCD accumulator, digit k at [k*4 +: 4]
//   last       : counter is 1, the step in this cycle is the final one
module bcd_dabble_core
    import bcd_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              shift_en,
    input  logic [WIDTH-1:0]  bin,
    output logic [NDIG*4-1:0] digits,
    output logic              last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [NDIG*4-1:0] acc_reg;
    logic [NDIG*4-1:0] acc_adj;
    logic [WIDTH-1:0]  sr_reg;
    logic [CW-1:0]     cnt_reg;

    // Each digit is corrected independently; the +3 never carries into the
    // next digit because a digit <= 9 plus 3 still fits in 4 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_adj
            logic [3:0] d;
            assign d = acc_reg[gi*4 +: 4];
            assign acc_adj[gi*4 +: 4] = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            sr_reg  <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            acc_reg <= '0;
            sr_reg  <= bin;
            cnt_reg <= CW'(WIDTH);
        end else if (shift_en && (cnt_reg != '0)) begin
            // {accumulator, value} << 1, after the per-digit correction
            {acc_reg, sr_reg} <= {acc_adj[NDIG*4-2:0], sr_reg, 1'b0};
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign digits = acc_reg;
    assign last   = (cnt_reg == CW'(1));

endmodule

// File: rtl/bcd_conversion_arbiter.sv
// Round-robin arbiter sharing one double-dabble BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bcd_conversion_arbiter_if (requests in,
//                ack pulses out, tagged BCD result with valid/ready)
// A grant is decided on the clock edge that leaves either an idle IDLE
// cycle or an accepted DONE cycle; the registered ack then shows up in
// the following IDLE cycle, after which WIDTH SHIFT cycles and one DONE
// cycle follow.
module bcd_conversion_arbiter
    import bcd_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int NDIG  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_conversion_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    generate
        if (NDIG < ndig_min(WIDTH)) begin : g_ndig_check
            $error("NDIG too small to hold 2^WIDTH-1");
        end
        if (WIDTH < 2) begin : g_width_check
            $error("WIDTH must be at least 2");
        end
        if (NREQ < 2) begin : g_nreq_check
            $error("NREQ must be at least 2");
        end
    endgenerate

    state_t            state_reg;
    state_t            state_next;
    logic [NREQ-1:0]   ack_reg;
    logic [IDW-1:0]    rr_ptr_reg;
    logic [IDW-1:0]    out_id_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    logic [IDW-1:0]    cand_idx [NREQ];
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic              grant_en;
    logic              accept;
    logic [WIDTH-1:0]  grant_value;
    logic [IDW-1:0]    rr_next;
    logic [NDIG*4-1:0] core_digits;
    logic              core_last;

    // Candidate k is the requester k places after rr_ptr, with wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDW'((int'(rr_ptr_reg) + gi) % NREQ);
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign accept      = (state_reg == DONE) && bus.out_ready;
    // No grant while the previous ack is still showing: that cycle starts
    // the conversion, and a req still high then is handled as a new request.
    assign grant_en    = grant_found &&
                         (((state_reg == IDLE) && (ack_reg == '0)) || accept);
    assign grant_value = bus.value[int'(grant_idx)*WIDTH +: WIDTH];
    assign rr_next     = IDW'((int'(grant_idx) + 1) % NREQ);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ack_reg != '0) state_next = SHIFT;
            SHIFT:   if (core_last)     state_next = DONE;
            DONE:    if (accept)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg       <= '0;
            rr_ptr_reg    <= '0;
            out_id_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            ack_reg <= grant_en ? (NREQ'(1) << grant_idx) : '0;
            if (grant_en) begin
                rr_ptr_reg <= rr_next;
                out_id_reg <= grant_idx;
            end
            out_valid_reg <= (state_next == DONE);
            busy_reg      <= (state_next != IDLE);
        end
    end

    bcd_dabble_core #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (grant_en),
        .shift_en (state_reg == SHIFT),
        .bin      (grant_value),
        .digits   (core_digits),
        .last     (core_last)
    );

    assign bus.ack        = ack_reg;
    assign bus.busy       = busy_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_id     = out_id_reg;
    assign bus.out_digits = core_digits;

endmodule

// File: doc/bcd_conversion_arbiter.md
# bcd_conversion_arbiter

Shares one sequential binary-to-BCD converter between up to NREQ requesters, such as the ALU result, operand A and operand B that feed the seven-segment display path. A round-robin arbiter grants one request at a time and latches its binary value. A shift-and-add-3 (double-dabble) engine then converts the value over WIDTH cycles. The result is presented with a valid/ready handshake to the display-driving logic, tagged with the granted requester's index.

## Interface
- WIDTH, 8, binary value width per requester (≥2)
- NREQ, 4, number of requesters (≥2)
- NDIG, 3, BCD digits produced; elaboration error unless 10^NDIG > 2^WIDTH − 1
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester request, level
- value  input  NREQ*WIDTH  packed values; requester i at [i*WIDTH +: WIDTH]
- ack  output  NREQ  one-hot, one-cycle pulse: value of that requester latched
- busy  output  1  high in any state except IDLE
- out_valid  output  1  conversion result available
- out_ready  input  1  consumer accepts result
- out_id  output  $clog2(NREQ)  index of the requester the result belongs to
- out_digits  output  NDIG*4  BCD result; digit k (10^k) at [k*4 +: 4]

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**:
  - If req ≠ 0, grant the first asserted req scanning upward from rr_ptr with wrap-around.
  - Pulse ack[g], latch value[g] into the shift register and g into out_id.
  - Clear the BCD accumulator, load bit counter = WIDTH, go to SHIFT.
  - Set rr_ptr = (g+1) mod NREQ.
- **SHIFT**, once per cycle:
  - Every accumulator digit ≥5 gets +3, using 4-bit unsigned arithmetic with no carry between digits.
  - Then shift {accumulator, value} left 1.
  - Decrement counter; at counter = 1, go to DONE.
- **DONE**:
  - out_valid = 1; out_digits and out_id are stable.
  - On out_valid & out_ready, go to IDLE.
  - No grant in the same cycle.
- **Requester rules**:
  - Hold value stable while req is high until ack.
  - Deasserting req before ack withdraws the request with no side effect.
  - A req still high the cycle after its ack is treated as a new request.
- **Arbitration**: requests arriving in SHIFT/DONE wait; no ack is issued outside IDLE.
- **Reset** (any time, including mid-SHIFT or DONE): state = IDLE, ack = 0, busy = 0, out_valid = 0, out_id = 0, out_digits = 0, rr_ptr = 0, counter = 0. Any in-flight conversion is discarded.
- **Boundaries**:
  - value 0 → all digits 0.
  - value 2^WIDTH−1 → exact decimal (255 → 2,5,5).
  - Upper unused digits read 0.

## Timing
- Grant cycle T (IDLE, ack high).
- SHIFT cycles T+1..T+WIDTH.
- out_valid first high at T+WIDTH+1.
- Ack-to-valid latency = WIDTH+1 cycles (9 for WIDTH=8).
- Minimum grant-to-grant spacing = WIDTH+2 cycles (out_ready tied high): DONE one cycle, IDLE grants in the next.
- ack, out_valid, out_id, out_digits and busy are all registered; no combinational path from req or out_ready to any output.
- out_digits is only meaningful while out_valid = 1. It holds its value while out_ready is low for any number of cycles.

## Structure
- Package bcd_conv_pkg:
  - state typedef enum {IDLE, SHIFT, DONE}
  - function ndig_min(width) for the elaboration check
  - localparam ADJ_THRESH = 4'd5, ADJ_ADD = 4'd3
- Sub-module bcd_dabble_core:
  - Accumulator, shift register and counter.
  - Inputs: start, bin.
  - Outputs: digits, last.
- Top level holds the round-robin arbiter, the FSM and the output handshake registers.

## Test plan
- Single request: req[2]=1, value[2]=173 → ack[2] at T; out_valid at T+9 with digits 1,7,3 and out_id=2; out_ready=1 → IDLE next cycle.
- All four requesters held high (values 10, 20, 30, 40) after reset → grant order 0,1,2,3,0 with outputs 010, 020, 030, 040; grants spaced exactly 10 cycles.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, out_id and out_digits stable; no ack while req[1] is pending; ack[1] in the cycle after the accepting out_ready.
- Boundaries: values 0, 9, 10, 99, 100, 255 → 000, 009, 010, 099, 100, 255.
- Reset mid-SHIFT (rst_n low at T+4) → all outputs 0 immediately; after release, with req[3] and req[0] both high, ack[0] is granted first (rr_ptr = 0).
- Withdrawal: req[1] pulses high only during SHIFT, then drops → no ack[1] is ever issued; the next grant goes to the other pending requester.
